rr_arbiter_n: RTL and testbench

//  N-way round-robin arbiter. It replaces the fixed 3-requester arbiter for shared-resource access.

---
 rtl/arb_pkg.sv | 17 +
 rtl/rr_pick.sv | 32 +++
 rtl/rr_arbiter_n.sv | 124 ++++++++++++
 tb/tb_rr_arbiter_n.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin arbiter.
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Index width for n items, never less than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: first set bit of req searching upward from ptr+1, wrapping.
module rr_pick
  import arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IW    = clog2_min1(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] pick,
  output logic [IW-1:0]    pick_id,
  output logic             any
);

  logic [IW-1:0] idx;

  always_comb begin
    pick    = '0;
    pick_id = '0;
    any     = 1'b0;
    idx     = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx = IW'((32'(ptr) + k) % N_REQ);
      if (!any && req[idx]) begin
        any       = 1'b1;
        pick[idx] = 1'b1;
        pick_id   = idx;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter_n.sv
// N-way round-robin arbiter with registered one-hot grant and owner hold timeout.
// Optional owner lock (suppresses the timeout) is enabled by defining ARB_LOCK_EN.
module rr_arbiter_n
  import arb_pkg::*;
#(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [N_REQ-1:0]             req,
`ifdef ARB_LOCK_EN
  input  logic                         lock,
`endif
  output logic [N_REQ-1:0]             grant,
  output logic                         grant_valid,
  output logic [clog2_min1(N_REQ)-1:0] grant_id
);

  localparam int unsigned IW = clog2_min1(N_REQ);
  localparam int unsigned HW = clog2_min1(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD - 1);

  arb_state_t       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic             valid_q, valid_d;
  logic [IW-1:0]    id_q, id_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [HW-1:0]    hold_q, hold_d;

  logic [N_REQ-1:0] pick;
  logic [IW-1:0]    pick_id;
  logic             pick_any;
  logic             lock_w;
  logic             take;

`ifdef ARB_LOCK_EN
  assign lock_w = lock;
`else
  assign lock_w = 1'b0;
`endif

  // Masking out the owner covers both release (owner bit already low) and timeout.
  rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_pick (
    .req     (req & ~grant_q),
    .ptr     (ptr_q),
    .pick    (pick),
    .pick_id (pick_id),
    .any     (pick_any)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    take    = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any) take = 1'b1;
      end
      GRANT: begin
        if (!req[id_q]) begin
          if (pick_any) begin
            take = 1'b1;
          end else begin
            state_d = IDLE;
            grant_d = '0;
            id_d    = '0;
            hold_d  = '0;
          end
        end else if (lock_w) begin
          // A locked owner restarts its timeout window once lock drops.
          hold_d = '0;
        end else if (hold_q == HOLD_MAX) begin
          if (pick_any) take = 1'b1;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        id_d    = '0;
        hold_d  = '0;
      end
    endcase
    if (take) begin
      state_d = GRANT;
      grant_d = pick;
      id_d    = pick_id;
      ptr_d   = pick_id;
      hold_d  = '0;
    end
    valid_d = |grant_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      grant_q <= '0;
      valid_q <= 1'b0;
      id_q    <= '0;
      ptr_q   <= IW'(N_REQ - 1);
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = valid_q;
  assign grant_id    = id_q;

endmodule

// File: tb/tb_rr_arbiter_n.sv
// Randomized self-checking bench for rr_arbiter_n against an owner/held-cycles reference model.
module tb_rr_arbiter_n;

  localparam int N  = 4;
  localparam int MH = 4;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic [N-1:0] req = '0;
  logic         lock_r = 1'b0;
  logic [N-1:0] grant;
  logic         grant_valid;
  logic [1:0]   grant_id;

  int checks = 0;
  int errors = 0;

  // Reference model: current owner (-1 = none), last granted index, cycles owned so far.
  int m_owner = -1;
  int m_ptr   = N - 1;
  int m_held  = 0;

  always #5 clk = ~clk;

  rr_arbiter_n #(
    .N_REQ    (N),
    .MAX_HOLD (MH)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .req         (req),
`ifdef ARB_LOCK_EN
    .lock        (lock_r),
`endif
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  function automatic int next_owner(input logic [N-1:0] r, input int p, input int excl);
    int i;
    for (int k = 1; k <= N; k++) begin
      i = (p + k) % N;
      if (r[i] && i != excl) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = N - 1;
    m_held  = 0;
  endtask

  task automatic model_take(input int nxt);
    m_owner = nxt;
    m_ptr   = nxt;
    m_held  = 1;
  endtask

  task automatic model_step(input logic [N-1:0] r, input logic lk);
    int nxt;
    if (m_owner < 0 || !r[m_owner]) begin
      nxt = next_owner(r, m_ptr, -1);
      if (nxt >= 0) model_take(nxt);
      else begin
        m_owner = -1;
        m_held  = 0;
      end
    end else if (lk) begin
      m_held = 1;
    end else if (m_held >= MH) begin
      nxt = next_owner(r, m_ptr, m_owner);
      if (nxt >= 0) model_take(nxt);
    end else begin
      m_held++;
    end
  endtask

  function automatic logic [6:0] exp_vec();
    if (m_owner < 0) return 7'd0;
    return {1'b1, 2'(m_owner), 4'(1 << m_owner)};
  endfunction

  // Drive req, let the DUT take an edge, advance the model, settle past the edge.
  task automatic cycle(input logic [N-1:0] r);
    req = r;
    @(posedge clk);
    model_step(r, lock_r);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    req  = '0;
    #1;
    model_reset();
    checks++;
    if ({grant_valid, grant_id, grant} !== 7'd0) begin
      errors++;
      $display("FAIL reset_async: got %b expected %b", {grant_valid, grant_id, grant}, 7'd0);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({grant_valid, grant_id, grant} !== 7'd0) begin
      errors++;
      $display("FAIL reset_held: got %b expected %b", {grant_valid, grant_id, grant}, 7'd0);
    end
    rstn = 1'b1;
  endtask

  task automatic test_rotation();
    for (int c = 0; c < 17; c++) begin
      cycle(4'b1111);
      checks++;
      if ({grant_valid, grant_id, grant} !== exp_vec()) begin
        errors++;
        $display("FAIL rotation_model c=%0d: got %b expected %b", c, {grant_valid, grant_id, grant}, exp_vec());
      end
      checks++;
      if (grant_id !== 2'((c / MH) % N) || grant_valid !== 1'b1) begin
        errors++;
        $display("FAIL rotation_order c=%0d: got id %0d valid %b expected id %0d valid 1",
                 c, grant_id, grant_valid, (c / MH) % N);
      end
    end
  endtask

  task automatic test_release();
    for (int c = 0; c < 4; c++) begin
      cycle(c < 2 ? 4'b0100 : 4'b0000);
      checks++;
      if ({grant_valid, grant_id, grant} !== exp_vec()) begin
        errors++;
        $display("FAIL release_model c=%0d: got %b expected %b", c, {grant_valid, grant_id, grant}, exp_vec());
      end
      checks++;
      if (grant !== (c < 2 ? 4'b0100 : 4'b0000) || grant_valid !== (c < 2)) begin
        errors++;
        $display("FAIL release_grant c=%0d: got %b/%b expected %b/%b", c, grant, grant_valid,
                 (c < 2 ? 4'b0100 : 4'b0000), (c < 2));
      end
    end
  endtask

  task automatic test_no_timeout();
    for (int c = 0; c < 10; c++) begin
      cycle(4'b0010);
      checks++;
      if (grant !== 4'b0010 || grant_id !== 2'd1) begin
        errors++;
        $display("FAIL lone_owner c=%0d: got %b id %0d expected 0010 id 1", c, grant, grant_id);
      end
    end
  endtask

  task automatic test_back_to_back();
    cycle(4'b0100);
    checks++;
    if (grant !== 4'b0100) begin
      errors++;
      $display("FAIL handover_setup: got %b expected 0100", grant);
    end
    cycle(4'b0001);
    checks++;
    if ({grant_valid, grant_id, grant} !== 7'b1_00_0001) begin
      errors++;
      $display("FAIL handover_direct: got %b expected %b", {grant_valid, grant_id, grant}, 7'b1_00_0001);
    end
    checks++;
    if ({grant_valid, grant_id, grant} !== exp_vec()) begin
      errors++;
      $display("FAIL handover_model: got %b expected %b", {grant_valid, grant_id, grant}, exp_vec());
    end
  endtask

  task automatic test_async_reset();
    cycle(4'b1000);
    cycle(4'b1000);
    checks++;
    if (grant !== 4'b1000) begin
      errors++;
      $display("FAIL midgrant_setup: got %b expected 1000", grant);
    end
    rstn = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({grant_valid, grant_id, grant} !== 7'd0) begin
      errors++;
      $display("FAIL midgrant_clear: got %b expected %b", {grant_valid, grant_id, grant}, 7'd0);
    end
    req = 4'b1010;
    #2;
    rstn = 1'b1;
    cycle(4'b1010);
    checks++;
    if ({grant_valid, grant_id, grant} !== 7'b1_01_0010) begin
      errors++;
      $display("FAIL post_reset_first: got %b expected %b", {grant_valid, grant_id, grant}, 7'b1_01_0010);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] r;
    r = '0;
    for (int c = 0; c < 400; c++) begin
      // Sticky requests with occasional flips so owners often run into the timeout.
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
      end
      cycle(r);
      checks++;
      if ({grant_valid, grant_id, grant} !== exp_vec()) begin
        errors++;
        $display("FAIL random_model c=%0d req=%b: got %b expected %b", c, r,
                 {grant_valid, grant_id, grant}, exp_vec());
      end
      checks++;
      if (!$onehot0(grant) || (grant & ~r) !== 4'b0000 || grant_valid !== (|grant)) begin
        errors++;
        $display("FAIL random_invariant c=%0d req=%b: got grant %b valid %b", c, r, grant, grant_valid);
      end
    end
  endtask

`ifdef ARB_LOCK_EN
  task automatic test_lock();
    rstn = 1'b0;
    req  = '0;
    lock_r = 1'b1;
    #2;
    model_reset();
    rstn = 1'b1;
    for (int c = 0; c < 8; c++) begin
      cycle(4'b0011);
      checks++;
      if (grant !== 4'b0001) begin
        errors++;
        $display("FAIL lock_hold c=%0d: got %b expected 0001", c, grant);
      end
    end
    lock_r = 1'b0;
    for (int c = 0; c < MH; c++) begin
      cycle(4'b0011);
      checks++;
      if (grant !== (c < MH - 1 ? 4'b0001 : 4'b0010)) begin
        errors++;
        $display("FAIL lock_release c=%0d: got %b expected %b", c, grant,
                 (c < MH - 1 ? 4'b0001 : 4'b0010));
      end
      checks++;
      if ({grant_valid, grant_id, grant} !== exp_vec()) begin
        errors++;
        $display("FAIL lock_model c=%0d: got %b expected %b", c, {grant_valid, grant_id, grant}, exp_vec());
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_rotation();
    test_release();
    test_no_timeout();
    test_back_to_back();
    test_async_reset();
    test_random();
`ifdef ARB_LOCK_EN
    test_lock();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
